fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 256 x 16 combinational instruction memory. Owns the program counter and drives the memory address. Captures each fetched word with its PC into a 2-entry buffer and presents it to decode over a valid/ready handshake. Handles branch/jump redirects (flush and reload PC) and stops fetching at a HALT instruction.

---
 rtl/fetch_ctrl.sv | 89 ++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer with 2-entry output buffer
// Owns the PC, pushes {pc, instr} into a 2-deep buffer, handles redirects and HALT.
module fetch_ctrl #(
  parameter int unsigned         ADDR_W      = 8,
  parameter int unsigned         INSTR_W     = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
  parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [1:0]         count_q, count_d;
  logic               halted_q;
  logic [INSTR_W-1:0] head_instr_q, tail_instr_q;
  logic [ADDR_W-1:0]  head_pc_q, tail_pc_q;

  logic pop, fetch, is_halt, load_head, load_tail;

  always_comb begin
    pop       = (count_q != 2'd0) & out_ready;
    fetch     = (state_q == S_RUN) & ~redirect_valid & ((count_q != 2'd2) | pop);
    is_halt   = (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);
    // New word lands at head when the buffer is (or becomes) empty, else behind it.
    load_head = fetch & ((count_q == 2'd0) | (pop & (count_q == 2'd1)));
    load_tail = fetch & (((count_q == 2'd1) & ~pop) | ((count_q == 2'd2) & pop));
    count_d   = count_q;
    if (fetch & ~pop)      count_d = count_q + 2'd1;
    else if (~fetch & pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      halted_q     <= 1'b0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
    end else if (redirect_valid) begin
      state_q  <= S_RUN;
      pc_q     <= redirect_pc;
      count_q  <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (fetch) begin
        pc_q <= pc_q + ADDR_W'(1);
        if (is_halt) begin
          state_q  <= S_HALT;
          halted_q <= 1'b1;
        end
      end
      if (pop & (count_q == 2'd2)) begin
        head_instr_q <= tail_instr_q;
        head_pc_q    <= tail_pc_q;
      end else if (load_head) begin
        head_instr_q <= imem_instr;
        head_pc_q    <= pc_q;
      end
      if (load_tail) begin
        tail_instr_q <= imem_instr;
        tail_pc_q    <= pc_q;
      end
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
// Stimulus pushes expected {pc, instr} words; a negedge monitor pops on each handshake.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;

  logic [15:0] mem [256];
  logic [23:0] exp_q [$];
  logic [23:0] mon_e;
  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr];

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] pc, input logic [15:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic wait_drain(output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 60) begin
      tick();
      cycles++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got pc=%0h instr=%0h expected none", out_pc, out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc", {24'd0, out_pc}, {24'd0, mon_e[23:16]});
        check("sb_instr", {16'd0, out_instr}, {16'd0, mon_e[15:0]});
      end
    end
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'(16'h1000 + k);
    rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;

    // Reset state, then streaming with no bubbles
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_halted", halted, 0);
    check("rst_addr", imem_addr, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) push(8'(k), 16'(16'h1000 + k));
    tick();
    check("stream_first_valid", out_valid, 1);
    check("stream_first_pc", out_pc, 0);
    wait_drain(n);
    check("stream_cycles", n, 8);
    out_ready = 1'b0;

    // Backpressure: buffer fills to 2 and PC freezes
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_addr", imem_addr, 8'h02);
      check("bp_valid", out_valid, 1);
      check("bp_instr", out_instr, 16'h1000);
    end
    for (int k = 0; k < 5; k++) push(8'(k), 16'(16'h1000 + k));
    out_ready = 1'b1;
    wait_drain(n);
    out_ready = 1'b0;

    // Redirect with a full buffer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("full_head_pc", out_pc, 0);
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid_low", out_valid, 0);
    check("redir_addr", imem_addr, 8'h40);
    tick();
    check("redir_valid_high", out_valid, 1);
    check("redir_pc", out_pc, 8'h40);
    check("redir_instr", out_instr, 16'h1040);
    push(8'h40, 16'h1040);
    push(8'h41, 16'h1041);
    push(8'h42, 16'h1042);
    out_ready = 1'b1;
    wait_drain(n);
    out_ready = 1'b0;

    // HALT at address 3
    mem[3] = 16'hF000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    push(8'h00, 16'h1000);
    push(8'h01, 16'h1001);
    push(8'h02, 16'h1002);
    push(8'h03, 16'hF000);
    wait_drain(n);
    repeat (3) tick();
    check("halt_halted", halted, 1);
    check("halt_addr", imem_addr, 8'h04);
    check("halt_valid", out_valid, 0);
    check("halt_last_instr", out_instr, 16'hF000);

    // Resume from HALT and wrap through 255
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    check("resume_halted", halted, 0);
    check("resume_addr", imem_addr, 8'hFE);
    push(8'hFE, 16'h10FE);
    push(8'hFF, 16'h10FF);
    push(8'h00, 16'h1000);
    push(8'h01, 16'h1001);
    wait_drain(n);
    out_ready = 1'b0;

    // Pop and redirect in the same cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    push(8'h00, 16'h1000);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h10;
    tick();
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    check("popredir_valid", out_valid, 0);
    check("popredir_consumed", exp_q.size(), 0);
    check("popredir_addr", imem_addr, 8'h10);
    tick();
    check("popredir_refill_valid", out_valid, 1);
    check("popredir_refill_pc", out_pc, 8'h10);

    // Reset during pop plus redirect
    push(8'h10, 16'h1010);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    check("midrst_addr", imem_addr, 8'h00);
    check("midrst_valid", out_valid, 0);
    check("midrst_halted", halted, 0);
    tick();
    tick();
    check("midrst_after_pc", out_pc, 8'h00);

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
